// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs instruction fields into 16-bit words and streams them to instruction memory
// Optional macro ENC_SKID_EN: adds a 1-entry skid buffer and a registered in_ready.
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  prog_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [2:0]        rd_index,
  input  logic [2:0]        rs_index,
  input  logic [2:0]        rt_index,
  input  logic [2:0]        shamt,
  input  logic [5:0]        constant,
  input  logic [8:0]        address,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;

  logic [15:0]       enc_word;
  logic              accept;
  logic              out_free;
  logic              drained;

  assign out_free = !mem_we_q || mem_ready;

`ifdef ENC_SKID_EN
  logic              skid_full_q, skid_full_d;
  logic [15:0]       skid_data_q, skid_data_d;
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
  logic              in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;
  // The load is finished only once the skid is empty and the last output write is taken
  assign drained  = !skid_full_q && mem_we_q && mem_ready;
`else
  assign in_ready = (state_q == S_RUN) && (remain_q != '0) && out_free;
  assign drained  = mem_we_q && mem_ready;
`endif

  assign accept = in_valid && in_ready;

  // Encode purely from the opcode class: 0-7 R, 8-11 I, 12-15 J
  always_comb begin
    enc_word = '0;
    if (!opcode[3]) begin
      enc_word = {opcode, rd_index, rs_index, rt_index, shamt};
    end else if (!opcode[2]) begin
      enc_word = {opcode, rd_index, rs_index, constant};
    end else begin
      enc_word = {opcode, address, 3'b000};
    end
  end

  // Load sequencing: capture on start, count accepts, finish after the last write drains
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d    = base_addr;
          remain_d = prog_len;
          if (prog_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          cnt_d    = cnt_q + ADDR_W'(1);
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (drained) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output register (and skid when enabled): reload on accept, hold while stalled
  always_comb begin
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef ENC_SKID_EN
    skid_full_d = skid_full_q;
    skid_data_d = skid_data_q;
    skid_addr_d = skid_addr_q;
    if (out_free) begin
      if (skid_full_q) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = skid_addr_q;
        mem_wdata_d = skid_data_q;
        skid_full_d = 1'b0;
      end else if (accept) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = cnt_q;
        mem_wdata_d = enc_word;
      end else begin
        mem_we_d    = 1'b0;
      end
    end
    // A word that cannot go straight to the output parks in the skid
    if (accept && (!out_free || skid_full_q)) begin
      skid_full_d = 1'b1;
      skid_data_d = enc_word;
      skid_addr_d = cnt_q;
    end
    in_ready_d = (state_d == S_RUN) && !skid_full_d && (remain_d != '0);
`else
    if (accept) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = cnt_q;
      mem_wdata_d = enc_word;
    end else if (mem_we_q && mem_ready) begin
      mem_we_d    = 1'b0;
    end
`endif
  end

  // State and datapath registers; reset discards any in-flight word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      remain_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
`ifdef ENC_SKID_EN
      skid_full_q <= 1'b0;
      skid_data_q <= '0;
      skid_addr_q <= '0;
      in_ready_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      remain_q    <= remain_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
`ifdef ENC_SKID_EN
      skid_full_q <= skid_full_d;
      skid_data_q <= skid_data_d;
      skid_addr_q <= skid_addr_d;
      in_ready_q  <= in_ready_d;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q == S_RUN);
  assign done      = done_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] prog_len;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic [2:0] rd_index, rs_index, rt_index, shamt;
  logic [5:0] constant;
  logic [8:0] address;
  logic       mem_we;
  logic       mem_ready;
  logic [7:0] mem_addr;
  logic [15:0] mem_wdata;
  logic       busy;
  logic       done;

  instr_encoder #(.ADDR_W(8), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .prog_len(prog_len),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .rd_index(rd_index),
    .rs_index(rs_index), .rt_index(rt_index), .shamt(shamt), .constant(constant),
    .address(address), .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rd, rs, rt, sh;
    logic [5:0]  c;
    logic [8:0]  a;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  vec_t vecs[9];
  wr_t  wr_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   done_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_addr;
  logic [15:0] prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, stall-hold checker and done counter, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_we", mem_we, 1);
        check("hold_addr", mem_addr, prev_addr);
        check("hold_data", mem_wdata, prev_data);
      end
      if (mem_we && mem_ready) wr_q.push_back('{mem_addr, mem_wdata, cyc});
      if (done) done_cnt++;
      prev_stall = mem_we && !mem_ready;
      prev_addr  = mem_addr;
      prev_data  = mem_wdata;
    end
  end

  task automatic set_fields(input vec_t v);
    opcode = v.op; rd_index = v.rd; rs_index = v.rs; rt_index = v.rt;
    shamt = v.sh; constant = v.c; address = v.a;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [7:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; prog_len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input vec_t v);
    int k;
    k = 0;
    set_fields(v);
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      k++;
      if (k > 50) begin
        check("send_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      k++;
      if (k > 100) begin
        check({name, "_done_timeout"}, 0, 1);
        return;
      end
    end
    @(negedge clk);
    check({name, "_done_pulse_1cyc"}, done, 0);
    check({name, "_busy_after"}, busy, 0);
  endtask

  task automatic check_wr(input string name, input int idx, input logic [7:0] ea, input logic [15:0] ed);
    if (idx < wr_q.size()) begin
      check({name, "_addr"}, wr_q[idx].addr, ea);
      check({name, "_data"}, wr_q[idx].data, ed);
    end else begin
      check({name, "_missing"}, wr_q.size(), idx + 1);
    end
  endtask

  initial begin
    int d0;
    vecs[0] = '{4'd3,  3'd5, 3'd2, 3'd7, 3'd1, 6'h3F, 9'h155, 16'h3AB9};
    vecs[1] = '{4'd9,  3'd1, 3'd4, 3'd7, 3'd7, 6'h2A, 9'h0F0, 16'h932A};
    vecs[2] = '{4'd13, 3'd7, 3'd7, 3'd7, 3'd7, 6'h15, 9'h1FF, 16'hDFF8};
    vecs[3] = '{4'd7,  3'd0, 3'd7, 3'd0, 3'd7, 6'h2B, 9'h1AA, 16'h71C7};
    vecs[4] = '{4'd8,  3'd7, 3'd0, 3'd5, 3'd3, 6'h01, 9'h123, 16'h8E01};
    vecs[5] = '{4'd11, 3'd2, 3'd5, 3'd1, 3'd6, 6'h30, 9'h0FF, 16'hB570};
    vecs[6] = '{4'd12, 3'd3, 3'd4, 3'd5, 3'd6, 6'h3F, 9'h001, 16'hC008};
    vecs[7] = '{4'd15, 3'd1, 3'd1, 3'd1, 3'd1, 6'h11, 9'h0AA, 16'hF550};
    vecs[8] = '{4'd0,  3'd0, 3'd0, 3'd0, 3'd0, 6'h3F, 9'h1FF, 16'h0000};

    rst_n = 1'b0; start = 1'b0; base_addr = '0; prog_len = '0;
    in_valid = 1'b0; mem_ready = 1'b1;
    set_fields(vecs[8]);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // in_valid in IDLE is ignored
    in_valid = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 0);
    in_valid = 1'b0;

    // R-type single word
    wr_q.delete();
    do_start(8'h10, 8'd1);
    check("r_busy", busy, 1);
    send(vecs[0]);
    wait_done("r");
    check("r_count", wr_q.size(), 1);
    check_wr("r_wr", 0, 8'h10, 16'h3AB9);

    // I then J back-to-back
    wr_q.delete();
    do_start(8'h20, 8'd2);
    send(vecs[1]);
    send(vecs[2]);
    wait_done("ij");
    check("ij_count", wr_q.size(), 2);
    check_wr("ij_wr0", 0, 8'h20, 16'h932A);
    check_wr("ij_wr1", 1, 8'h21, 16'hDFF8);
    if (wr_q.size() == 2) check("ij_consecutive", wr_q[1].cyc - wr_q[0].cyc, 1);

    // Table-driven load of every vector
    wr_q.delete();
    do_start(8'h40, 8'd9);
    for (int i = 0; i < 9; i++) send(vecs[i]);
    wait_done("tbl");
    check("tbl_count", wr_q.size(), 9);
    for (int i = 0; i < 9; i++) check_wr($sformatf("tbl_wr%0d", i), i, 8'(8'h40 + i), vecs[i].exp);

    // Backpressure: memory stalls 4 cycles with a word pending
    wr_q.delete();
    do_start(8'h80, 8'd3);
    send(vecs[3]);
    send(vecs[4]);
    mem_ready = 1'b0;
    set_fields(vecs[5]);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("bp_in_ready%0d", i), in_ready, 0);
      check($sformatf("bp_we%0d", i), mem_we, 1);
      check($sformatf("bp_addr%0d", i), mem_addr, 8'h81);
      check($sformatf("bp_data%0d", i), mem_wdata, 16'h8E01);
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    send(vecs[5]);
    wait_done("bp");
    check("bp_count", wr_q.size(), 3);
    check_wr("bp_wr0", 0, 8'h80, 16'h71C7);
    check_wr("bp_wr1", 1, 8'h81, 16'h8E01);
    check_wr("bp_wr2", 2, 8'h82, 16'hB570);

    // Address wrap
    wr_q.delete();
    do_start(8'hFF, 8'd2);
    send(vecs[6]);
    send(vecs[7]);
    wait_done("wrap");
    check("wrap_count", wr_q.size(), 2);
    check_wr("wrap_wr0", 0, 8'hFF, 16'hC008);
    check_wr("wrap_wr1", 1, 8'h00, 16'hF550);

    // Zero-length load
    wr_q.delete();
    do_start(8'h33, 8'd0);
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_we", mem_we, 0);
    @(negedge clk);
    check("zero_done_drop", done, 0);
    check("zero_count", wr_q.size(), 0);

    // Reset in the middle of a load, then a fresh load
    wr_q.delete();
    do_start(8'h50, 8'd4);
    send(vecs[0]);
    send(vecs[1]);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_data", mem_wdata, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_no_done", done_cnt - d0, 0);
    check("mid_rst_count", wr_q.size(), 1);
    check_wr("mid_rst_wr0", 0, 8'h50, 16'h3AB9);
    wr_q.delete();
    do_start(8'h60, 8'd1);
    send(vecs[2]);
    wait_done("fresh");
    check("fresh_count", wr_q.size(), 1);
    check_wr("fresh_wr", 0, 8'h60, 16'hDFF8);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
